// File: rtl/tx_serial_uart_param.sv
`default_nettype none
// ============================================================================
//  Module   : tx_serial_uart_param
//  Purpose  : Parametrised asynchronous serial transmitter (control + datapath)
//             with a start/ready handshake. Frame = start(0), DATA_BITS data
//             bits LSB first, optional parity bit, STOP_BITS stop bits (1).
//  Ports    : clock        - system clock, rising edge
//             reset        - asynchronous, active-low
//             partida      - send request, level-sampled each edge
//             dados        - payload, captured on the accepting edge
//             saida_serial - serial line, idle high
//             ocupado      - high while a frame is shifted out
//             pronto       - one-cycle pulse after the last stop bit
//             buffer_cheio - holding register occupied (0 without buffer)
//  Options  : TX_BUFFER_EN - when defined, adds a single-entry holding
//             register so a request made while busy is sent right after the
//             current frame with a one-clock idle gap.
//  Revision : 1.0 - initial release
// ============================================================================
module tx_serial_uart_param #(
    parameter int DATA_BITS    = 7,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 2,
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 partida,
    input  logic [DATA_BITS-1:0] dados,
    output logic                 saida_serial,
    output logic                 ocupado,
    output logic                 pronto,
    output logic                 buffer_cheio
);

    localparam int c_PAR_BITS   = (PARITY != 0) ? 1 : 0;
    localparam int c_FRAME_BITS = 1 + DATA_BITS + c_PAR_BITS + STOP_BITS;
    localparam int c_TICK_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    // Elaboration-time parameter checks
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("tx_serial_uart_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("tx_serial_uart_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("tx_serial_uart_param: STOP_BITS must be 1..2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("tx_serial_uart_param: CLKS_PER_BIT must be >= 2");
    end

    typedef enum logic [1:0] {
        REPOUSO     = 2'd0,
        TRANSMISSAO = 2'd1,
        FIM         = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_FRAME_BITS-1:0] r_shift;
    logic [c_TICK_W-1:0]     r_tick;
    logic [3:0]              r_bit;
    logic                    w_accept;
    logic                    w_tick_end;
    logic                    w_bit_last;

    // Whole frame laid out LSB-first so the line is always r_shift[0];
    // positions above the parity bit are stop bits (ones).
    function automatic logic [c_FRAME_BITS-1:0] f_build_frame(input logic [DATA_BITS-1:0] d);
        logic [c_FRAME_BITS-1:0] v;
        v              = '1;
        v[0]           = 1'b0;
        v[DATA_BITS:1] = d;
        if (PARITY == 1)
            v[DATA_BITS+1] = ^d;
        else if (PARITY == 2)
            v[DATA_BITS+1] = ~^d;
        return v;
    endfunction

    assign w_tick_end = (r_tick == c_TICK_W'(CLKS_PER_BIT - 1));
    assign w_bit_last = (r_bit == 4'(c_FRAME_BITS - 1));

`ifdef TX_BUFFER_EN
    logic [DATA_BITS-1:0] r_buf;
    logic                 r_buf_full;
    logic                 w_load_buf;
    logic                 w_capture;

    assign buffer_cheio = r_buf_full;
`else
    assign buffer_cheio = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= REPOUSO;
        else
            r_state <= w_state_next;
    end

    // Next-state and outputs
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        saida_serial = 1'b1;
        ocupado      = 1'b0;
        pronto       = 1'b0;
`ifdef TX_BUFFER_EN
        w_load_buf   = 1'b0;
        w_capture    = 1'b0;
`endif
        case (r_state)
            REPOUSO: begin
                if (partida) begin
                    w_accept     = 1'b1;
                    w_state_next = TRANSMISSAO;
                end
            end
            TRANSMISSAO: begin
                ocupado      = 1'b1;
                saida_serial = r_shift[0];
                if (w_tick_end && w_bit_last)
                    w_state_next = FIM;
`ifdef TX_BUFFER_EN
                w_capture = partida && !r_buf_full;
`endif
            end
            FIM: begin
                pronto = 1'b1;
`ifdef TX_BUFFER_EN
                // A buffered frame has priority; a request in this same
                // cycle refills the buffer that is being emptied.
                if (r_buf_full) begin
                    w_load_buf   = 1'b1;
                    w_capture    = partida;
                    w_state_next = TRANSMISSAO;
                end else
`endif
                if (partida) begin
                    w_accept     = 1'b1;
                    w_state_next = TRANSMISSAO;
                end else begin
                    w_state_next = REPOUSO;
                end
            end
            default: w_state_next = REPOUSO;
        endcase
    end

    // Shift register and bit timing
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shift <= '1;
            r_tick  <= '0;
            r_bit   <= 4'd0;
        end else if (w_accept) begin
            r_shift <= f_build_frame(dados);
            r_tick  <= '0;
            r_bit   <= 4'd0;
`ifdef TX_BUFFER_EN
        end else if (w_load_buf) begin
            r_shift <= f_build_frame(r_buf);
            r_tick  <= '0;
            r_bit   <= 4'd0;
`endif
        end else if (r_state == TRANSMISSAO) begin
            if (w_tick_end) begin
                r_tick  <= '0;
                r_shift <= {1'b1, r_shift[c_FRAME_BITS-1:1]};
                r_bit   <= w_bit_last ? 4'd0 : r_bit + 4'd1;
            end else begin
                r_tick <= r_tick + c_TICK_W'(1);
            end
        end
    end

`ifdef TX_BUFFER_EN
    // Single-entry holding register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
        end else if (w_capture) begin
            r_buf      <= dados;
            r_buf_full <= 1'b1;
        end else if (w_load_buf) begin
            r_buf_full <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tx_serial_uart_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_serial_uart_param
//  Purpose  : Self-checking bench for tx_serial_uart_param. Three instances:
//             7N2, 8E1 and 8O1, all with 4 clocks per bit. Expected frames
//             are queued when a request is driven and compared bit-by-bit
//             against the line while the instance reports busy.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tx_serial_uart_param;

    localparam int CPB = 4;

    logic       clk;
    logic       rst_n;
    logic [2:0] start;
    logic [6:0] dados_a;
    logic [7:0] dados_b;
    logic [7:0] dados_c;
    logic [2:0] line;
    logic [2:0] busy;
    logic [2:0] done;
    logic [2:0] bfull;

    int n_cmp = 0;
    int n_err = 0;

    logic [12:0] q0[$];
    logic [12:0] q1[$];
    logic [12:0] q2[$];

    tx_serial_uart_param #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(CPB)) u_a (
        .clock(clk), .reset(rst_n), .partida(start[0]), .dados(dados_a),
        .saida_serial(line[0]), .ocupado(busy[0]), .pronto(done[0]), .buffer_cheio(bfull[0]));

    tx_serial_uart_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) u_b (
        .clock(clk), .reset(rst_n), .partida(start[1]), .dados(dados_b),
        .saida_serial(line[1]), .ocupado(busy[1]), .pronto(done[1]), .buffer_cheio(bfull[1]));

    tx_serial_uart_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) u_c (
        .clock(clk), .reset(rst_n), .partida(start[2]), .dados(dados_c),
        .saida_serial(line[2]), .ocupado(busy[2]), .pronto(done[2]), .buffer_cheio(bfull[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference frames, bit 0 = start bit
    function automatic logic [12:0] frame7(input logic [6:0] d);
        return {3'b000, 2'b11, d, 1'b0};
    endfunction

    function automatic logic [12:0] frame8(input logic [7:0] d, input logic odd);
        return {2'b00, 1'b1, (^d) ^ odd, d, 1'b0};
    endfunction

    function automatic int frame_len(input int k);
        return (k == 0) ? 10 : 11;
    endfunction

    task automatic push_exp(input int k, input logic [12:0] f);
        case (k)
            0:       q0.push_back(f);
            1:       q1.push_back(f);
            default: q2.push_back(f);
        endcase
    endtask

    task automatic pop_exp(input int k, output logic [12:0] f);
        int sz;
        case (k)
            0:       sz = q0.size();
            1:       sz = q1.size();
            default: sz = q2.size();
        endcase
        check($sformatf("frame_expected%0d", k), (sz > 0) ? 32'd1 : 32'd0, 32'd1);
        f = '1;
        if (sz > 0) begin
            case (k)
                0:       f = q0.pop_front();
                1:       f = q1.pop_front();
                default: f = q2.pop_front();
            endcase
        end
    endtask

    // Line monitor / scoreboard
    int          mcyc[3];
    bit          mact[3];
    logic [12:0] mexp[3];

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                mact[k] = 1'b0;
                check($sformatf("rst_line%0d", k), 32'(line[k]), 32'd1);
                check($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd0);
            end else if (busy[k]) begin
                if (!mact[k]) begin
                    mact[k] = 1'b1;
                    mcyc[k] = 0;
                    pop_exp(k, mexp[k]);
                end
                if (mcyc[k] < frame_len(k) * CPB)
                    check($sformatf("line%0d_c%0d", k, mcyc[k]), 32'(line[k]),
                          32'(mexp[k][mcyc[k] / CPB]));
                check($sformatf("pronto_busy%0d", k), 32'(done[k]), 32'd0);
                mcyc[k]++;
            end else begin
                if (mact[k]) begin
                    mact[k] = 1'b0;
                    check($sformatf("busy_len%0d", k), mcyc[k], frame_len(k) * CPB);
                    check($sformatf("pronto_end%0d", k), 32'(done[k]), 32'd1);
                end else begin
                    check($sformatf("pronto_idle%0d", k), 32'(done[k]), 32'd0);
                end
                check($sformatf("line_idle%0d", k), 32'(line[k]), 32'd1);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pronto(input int k, input int budget);
        int n;
        n = 0;
        while (done[k] !== 1'b1 && n < budget) begin
            wait_clk(1);
            n++;
        end
        check($sformatf("pronto_seen%0d", k), 32'(done[k]), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 3'b000;
        dados_a = '0;
        dados_b = '0;
        dados_c = '0;
        wait_clk(3);
        check("reset_line", 32'(line[0]), 32'd1);
        check("reset_busy", 32'(busy[0]), 32'd0);
        check("reset_pronto", 32'(done[0]), 32'd0);
        check("reset_bfull", 32'(bfull[0]), 32'd0);
        rst_n = 1'b1;
        wait_clk(2);

        // 7N2 frame of 0x41, start bit right after the accepting edge
        dados_a  = 7'h41;
        start[0] = 1'b1;
        push_exp(0, frame7(7'h41));
        wait_clk(1);
        start[0] = 1'b0;
        check("t1_start_bit", 32'(line[0]), 32'd0);
        check("t1_busy", 32'(busy[0]), 32'd1);
        wait_pronto(0, 60);
        wait_clk(1);
        check("t1_idle_after", 32'(busy[0]), 32'd0);

        // Parity frames: even and odd, two patterns
        dados_b = 8'hA5;
        dados_c = 8'hA5;
        start[2:1] = 2'b11;
        push_exp(1, frame8(8'hA5, 1'b0));
        push_exp(2, frame8(8'hA5, 1'b1));
        wait_clk(1);
        start[2:1] = 2'b00;
        wait_pronto(1, 60);
        wait_clk(1);
        dados_b = 8'h01;
        dados_c = 8'h01;
        start[2:1] = 2'b11;
        push_exp(1, frame8(8'h01, 1'b0));
        push_exp(2, frame8(8'h01, 1'b1));
        wait_clk(1);
        start[2:1] = 2'b00;
        wait_pronto(2, 60);
        wait_clk(1);

`ifndef TX_BUFFER_EN
        // Request during transmission is ignored
        dados_a  = 7'h55;
        start[0] = 1'b1;
        push_exp(0, frame7(7'h55));
        wait_clk(1);
        start[0] = 1'b0;
        wait_clk(18);
        dados_a  = 7'h7F;
        start[0] = 1'b1;
        wait_clk(1);
        start[0] = 1'b0;
        check("t3_bfull_tied", 32'(bfull[0]), 32'd0);
        wait_pronto(0, 60);
        wait_clk(20);
        check("t3_no_extra_frame", 32'(busy[0]), 32'd0);
`else
        // Holding register: 31 sent, 32 buffered, 33 dropped
        dados_a  = 7'h31;
        start[0] = 1'b1;
        push_exp(0, frame7(7'h31));
        wait_clk(1);
        start[0] = 1'b0;
        check("t5_bfull_empty", 32'(bfull[0]), 32'd0);
        wait_clk(5);
        dados_a  = 7'h32;
        start[0] = 1'b1;
        push_exp(0, frame7(7'h32));
        wait_clk(1);
        start[0] = 1'b0;
        check("t5_bfull_set", 32'(bfull[0]), 32'd1);
        wait_clk(5);
        dados_a  = 7'h33;
        start[0] = 1'b1;
        wait_clk(1);
        start[0] = 1'b0;
        check("t5_bfull_hold", 32'(bfull[0]), 32'd1);
        wait_pronto(0, 60);
        wait_clk(1);
        check("t5_gap_busy", 32'(busy[0]), 32'd1);
        check("t5_gap_start", 32'(line[0]), 32'd0);
        check("t5_bfull_clear", 32'(bfull[0]), 32'd0);
        wait_pronto(0, 60);
        wait_clk(1);
        check("t5_done_idle", 32'(busy[0]), 32'd0);
        wait_clk(10);
`endif

        // Asynchronous reset during data bit 3, then a clean frame
        dados_a  = 7'h2A;
        start[0] = 1'b1;
        push_exp(0, frame7(7'h2A));
        wait_clk(1);
        start[0] = 1'b0;
        wait_clk(17);
        #1;
        rst_n = 1'b0;
        #1;
        check("t4_async_line", 32'(line[0]), 32'd1);
        check("t4_async_busy", 32'(busy[0]), 32'd0);
        check("t4_async_pronto", 32'(done[0]), 32'd0);
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(1);
        dados_a  = 7'h6C;
        start[0] = 1'b1;
        push_exp(0, frame7(7'h6C));
        wait_clk(1);
        start[0] = 1'b0;
        wait_pronto(0, 60);
        wait_clk(2);

`ifndef TX_BUFFER_EN
        // partida held high: back-to-back frames, 1-clock gap
        dados_a  = 7'h12;
        start[0] = 1'b1;
        push_exp(0, frame7(7'h12));
        wait_clk(1);
        wait_clk(10);
        dados_a = 7'h23;
        wait_pronto(0, 60);
        push_exp(0, frame7(7'h23));
        wait_clk(1);
        check("t6_gap1_busy", 32'(busy[0]), 32'd1);
        wait_clk(10);
        dados_a = 7'h34;
        wait_pronto(0, 60);
        push_exp(0, frame7(7'h34));
        wait_clk(1);
        check("t6_gap2_busy", 32'(busy[0]), 32'd1);
        start[0] = 1'b0;
        dados_a  = 7'h7F;
        wait_pronto(0, 60);
        wait_clk(1);
        check("t6_stop", 32'(busy[0]), 32'd0);
`endif

        wait_clk(20);
        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);
        check("q2_drained", q2.size(), 32'd0);
        check("bfull_b", 32'(bfull[1]), 32'd0);
        check("bfull_c", 32'(bfull[2]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
